// File: rtl/alu_exec.sv
// Purpose    : execution-stage ALU (AND/OR/ADD/SUB/SLT/illegal, iterative unsigned MULT into HI/LO).
// Latency    : 1 cycle for single-cycle ops, DATA_W cycles for MULT.
// Backpressure: valid/ready; result and flags hold while oValid && !iReady, oReady low during MULT.
//
// Ports:
//   iClk, iRst         clock, synchronous active-high reset
//   iValid/oReady      request handshake carrying iOp, iA, iB
//   oValid/iReady      result handshake carrying oResult, oZero, oOverflow, oIllegal
//   oHi, oLo           product halves of the last completed MULT
//   oBusy              multiply in progress
module alu_exec #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    output logic              oReady,
    input  logic [OP_W-1:0]   iOp,
    input  logic [DATA_W-1:0] iA,
    input  logic [DATA_W-1:0] iB,
    output logic              oValid,
    input  logic              iReady,
    output logic [DATA_W-1:0] oResult,
    output logic              oZero,
    output logic              oOverflow,
    output logic              oIllegal,
    output logic [DATA_W-1:0] oHi,
    output logic [DATA_W-1:0] oLo,
    output logic              oBusy
);

    localparam int MSB   = DATA_W - 1;
    localparam int CNT_W = $clog2(DATA_W);

    localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'h01);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'h06);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6'h07);
    localparam logic [OP_W-1:0] OP_MULT = OP_W'(6'h0C);

    typedef enum logic {IDLE, MUL} state_t;

    state_t                state;
    state_t                stateNext;

    logic [2*DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0]   acc;
    logic [2*DATA_W-1:0]   accNext;
    logic [DATA_W-1:0]     mplier;
    logic [CNT_W-1:0]      cnt;

    logic                  accept;
    logic                  isMult;
    logic                  mulLast;

    logic [DATA_W-1:0]     sumAB;
    logic [DATA_W-1:0]     diffAB;
    logic                  addOvf;
    logic                  subOvf;
    logic [DATA_W-1:0]     aluRes;
    logic                  aluOvf;
    logic                  aluIll;

    // A new request may enter only when idle and the output slot is free
    // (or being freed this very edge).
    assign oReady  = !iRst && (state == IDLE) && (!oValid || iReady);
    assign accept  = iValid && oReady;
    assign isMult  = (iOp == OP_MULT);
    assign oBusy   = (state == MUL);
    assign mulLast = (state == MUL) && (cnt == CNT_W'(DATA_W - 1));
    assign accNext = acc + (mplier[0] ? mcand : '0);

    // Single-cycle datapath; only ever lands in registers.
    always_comb begin
        sumAB  = iA + iB;
        diffAB = iA - iB;
        addOvf = (iA[MSB] == iB[MSB]) && (sumAB[MSB] != iA[MSB]);
        subOvf = (iA[MSB] != iB[MSB]) && (diffAB[MSB] != iA[MSB]);
        aluRes = '0;
        aluOvf = 1'b0;
        aluIll = 1'b0;
        case (iOp)
            OP_AND: aluRes = iA & iB;
            OP_OR:  aluRes = iA | iB;
            OP_ADD: begin
                aluRes = sumAB;
                aluOvf = addOvf;
            end
            OP_SUB: begin
                aluRes = diffAB;
                aluOvf = subOvf;
            end
            // Signed less-than stays correct even when A-B wraps.
            OP_SLT: aluRes = {{(DATA_W-1){1'b0}}, diffAB[MSB] ^ subOvf};
            default: aluIll = 1'b1;
        endcase
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept && isMult) stateNext = MUL;
            MUL:  if (mulLast)          stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) state <= IDLE;
        else      state <= stateNext;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oValid    <= 1'b0;
            oResult   <= '0;
            oZero     <= 1'b0;
            oOverflow <= 1'b0;
            oIllegal  <= 1'b0;
            oHi       <= '0;
            oLo       <= '0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            if (oValid && iReady) oValid <= 1'b0;

            if (state == IDLE) begin
                if (accept) begin
                    if (isMult) begin
                        mcand  <= {{DATA_W{1'b0}}, iA};
                        mplier <= iB;
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        oResult   <= aluRes;
                        oZero     <= (aluRes == '0);
                        oOverflow <= aluOvf;
                        oIllegal  <= aluIll;
                        oValid    <= 1'b1;
                    end
                end
            end else begin
                acc    <= accNext;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CNT_W'(1);
                // Last partial product is folded in on the same edge the
                // result is published.
                if (mulLast) begin
                    oHi       <= accNext[2*DATA_W-1:DATA_W];
                    oLo       <= accNext[DATA_W-1:0];
                    oResult   <= accNext[DATA_W-1:0];
                    oZero     <= (accNext[DATA_W-1:0] == '0);
                    oOverflow <= 1'b0;
                    oIllegal  <= 1'b0;
                    oValid    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Purpose    : self-checking bench for alu_exec (vector table + scoreboard + corner sequences).
// Latency    : results matched in order against a queue of expected records.
// Backpressure: iReady is toggled to exercise output hold and back-to-back retire.
module tb_alu_exec;

    logic        iClk;
    logic        iRst;
    logic        iValid;
    logic        oReady;
    logic [5:0]  iOp;
    logic [31:0] iA;
    logic [31:0] iB;
    logic        oValid;
    logic        iReady;
    logic [31:0] oResult;
    logic        oZero;
    logic        oOverflow;
    logic        oIllegal;
    logic [31:0] oHi;
    logic [31:0] oLo;
    logic        oBusy;

    alu_exec #(.DATA_W(32), .OP_W(6)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iOp(iOp), .iA(iA), .iB(iB), .oValid(oValid), .iReady(iReady),
        .oResult(oResult), .oZero(oZero), .oOverflow(oOverflow),
        .oIllegal(oIllegal), .oHi(oHi), .oLo(oLo), .oBusy(oBusy)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
        logic [31:0] hi;
        logic [31:0] lo;
    } sb_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[16];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkOut(input sb_t e);
        chk("result", oResult, e.res);
        chk("zero", {31'b0, oZero}, {31'b0, e.zero});
        chk("overflow", {31'b0, oOverflow}, {31'b0, e.ovf});
        chk("illegal", {31'b0, oIllegal}, {31'b0, e.ill});
        chk("hi", oHi, e.hi);
        chk("lo", oLo, e.lo);
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, " oValid"}, {31'b0, oValid}, 32'd0);
        chk({tag, " oResult"}, oResult, 32'd0);
        chk({tag, " oZero"}, {31'b0, oZero}, 32'd0);
        chk({tag, " oOverflow"}, {31'b0, oOverflow}, 32'd0);
        chk({tag, " oIllegal"}, {31'b0, oIllegal}, 32'd0);
        chk({tag, " oHi"}, oHi, 32'd0);
        chk({tag, " oLo"}, oLo, 32'd0);
        chk({tag, " oBusy"}, {31'b0, oBusy}, 32'd0);
    endtask

    // One clock: observe handshakes mid-low-phase, then advance past the edge.
    task automatic step(input sb_t expIn, output logic accepted);
        #2;
        if (oValid && iReady) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected output: got %h expected none", oResult);
            end else begin
                chkOut(sb.pop_front());
            end
        end
        accepted = iValid && oReady;
        if (accepted) sb.push_back(expIn);
        @(posedge iClk);
        #1;
    endtask

    task automatic drain();
        logic got;
        sb_t  none;
        none = '0;
        for (int t = 0; t < 100 && sb.size() != 0; t++) step(none, got);
        if (sb.size() != 0) begin
            chk("drain timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input sb_t e, input string name);
        logic got;
        iOp = op; iA = a; iB = b; iValid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) step(e, got);
        if (!got) chk({name, " accept timeout"}, 32'd0, 32'd1);
    endtask

    function automatic sb_t mkExp(input vec_t v);
        sb_t e;
        e.res = v.res; e.zero = v.zero; e.ovf = v.ovf; e.ill = v.ill;
        e.hi = v.hi; e.lo = v.lo;
        return e;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        int   n;
        sb_t  e;
        sb_t  none;
        none = '0;

        //            op     a             b             res           z     o     i     hi            lo
        vecs[0]  = '{6'h02, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
        vecs[1]  = '{6'h06, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[2]  = '{6'h07, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[3]  = '{6'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[4]  = '{6'h01, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[5]  = '{6'h02, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[6]  = '{6'h06, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
        vecs[7]  = '{6'h07, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[8]  = '{6'h07, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[9]  = '{6'h0C, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 32'h1,        32'hFFFFFFFE};
        vecs[10] = '{6'h3F, 32'h00000123, 32'h00000456, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h1,        32'hFFFFFFFE};
        vecs[11] = '{6'h0C, 32'h00000000, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[12] = '{6'h02, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        vecs[13] = '{6'h0C, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h1,        32'h0};
        vecs[14] = '{6'h06, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 32'h1,        32'h0};
        vecs[15] = '{6'h03, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b1, 32'h1,        32'h0};

        iRst = 1'b1; iValid = 1'b0; iReady = 1'b1;
        iOp = 6'h00; iA = 32'h0; iB = 32'h0;
        repeat (2) @(posedge iClk);
        #1;
        #1;
        chk("ready in reset", {31'b0, oReady}, 32'd0);
        chkIdle("reset");
        iRst = 1'b0;
        #1;
        chk("ready after reset", {31'b0, oReady}, 32'd1);

        // Vector table, streamed with iReady held high.
        for (int i = 0; i < 16; i++)
            issue(vecs[i].op, vecs[i].a, vecs[i].b, mkExp(vecs[i]), "vector");
        iValid = 1'b0;
        drain();

        // MULT latency and busy/ready behaviour during the iteration.
        e = '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 32'h1, 32'hFFFFFFFE};
        issue(6'h0C, 32'hFFFFFFFF, 32'h00000002, e, "mult");
        iValid = 1'b1;
        iOp = 6'h02; iA = 32'h1; iB = 32'h1;
        n = 0;
        for (int t = 0; t < 100; t++) begin
            #1;
            if (oValid) break;
            chk("mult busy", {31'b0, oBusy}, 32'd1);
            chk("mult ready", {31'b0, oReady}, 32'd0);
            n++;
            step(none, got);
        end
        iValid = 1'b0;
        chk("mult latency", n, 32'd32);
        chk("mult oResult==oLo", oResult, 32'hFFFFFFFE);
        drain();

        // Back-pressure: AND held for 5 cycles, queued OR retires back-to-back.
        iReady = 1'b0;
        e = '{32'hF000F000, 1'b0, 1'b0, 1'b0, 32'h1, 32'hFFFFFFFE};
        issue(6'h00, 32'hF0F0F0F0, 32'hFF00FF00, e, "and");
        e = '{32'h0F0F00F0, 1'b0, 1'b0, 1'b0, 32'h1, 32'hFFFFFFFE};
        iOp = 6'h01; iA = 32'h0F0F0000; iB = 32'h000000F0; iValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold valid", {31'b0, oValid}, 32'd1);
            chk("hold result", oResult, 32'hF000F000);
            chk("hold ready", {31'b0, oReady}, 32'd0);
            step(e, got);
            chk("hold no accept", {31'b0, got}, 32'd0);
        end
        iReady = 1'b1;
        step(e, got);
        chk("b2b accept", {31'b0, got}, 32'd1);
        iValid = 1'b0;
        #1;
        chk("b2b valid", {31'b0, oValid}, 32'd1);
        chk("b2b result", oResult, 32'h0F0F00F0);
        drain();

        // Reset in the middle of a multiply.
        issue(6'h0C, 32'h7, 32'h9, none, "mult abort");
        iValid = 1'b0;
        repeat (10) step(none, got);
        chk("mid-mult busy", {31'b0, oBusy}, 32'd1);
        iRst = 1'b1;
        #1;
        chk("ready in mid reset", {31'b0, oReady}, 32'd0);
        step(none, got);
        sb.delete();
        iRst = 1'b0;
        #1;
        chkIdle("abort");
        chk("ready after abort", {31'b0, oReady}, 32'd1);
        e = '{32'h5, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        issue(6'h02, 32'h2, 32'h3, e, "add after abort");
        iValid = 1'b0;
        #1;
        chk("add latency", {31'b0, oValid}, 32'd1);
        chk("add after abort result", oResult, 32'h5);
        drain();

        // Reset coinciding with a request: nothing captured.
        iRst = 1'b1; iValid = 1'b1;
        iOp = 6'h02; iA = 32'h1; iB = 32'h1;
        #1;
        chk("ready with reset+valid", {31'b0, oReady}, 32'd0);
        step(none, got);
        chk("reset wins accept", {31'b0, got}, 32'd0);
        iRst = 1'b0; iValid = 1'b0;
        #1;
        chk("no result after reset+valid", {31'b0, oValid}, 32'd0);
        step(none, got);
        chk("still no result", {31'b0, oValid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execution-stage ALU for the MIPS core. It consumes the 6-bit operation code produced by the ALU control decoder plus two operands, and returns a registered result with zero and overflow flags over a valid/ready handshake. Single-cycle ops (AND/OR/ADD/SUB/SLT) complete in one cycle. Unsigned MULT runs as an iterative shift-add state machine and writes HI/LO. The zero flag drives the branch-equal decision in the pipeline.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 6, op code width (matches `ALU_CNTL_OP_W`)

- iClk  input  1  clock; all state updates on rising edge
- iRst  input  1  synchronous, active-high reset
- iValid  input  1  request valid
- oReady  output  1  block can accept a request this cycle
- iOp  input  OP_W  operation code
- iA  input  DATA_W  operand A (rs)
- iB  input  DATA_W  operand B (rt/immediate)
- oValid  output  1  result valid
- iReady  input  1  downstream accepts result
- oResult  output  DATA_W  result (LO for MULT)
- oZero  output  1  oResult == 0
- oOverflow  output  1  signed overflow (ADD/SUB only)
- oIllegal  output  1  op code not in supported set
- oHi  output  DATA_W  HI register (upper product half)
- oLo  output  DATA_W  LO register (lower product half)
- oBusy  output  1  multiply in progress

## Operation
Op codes are as follows:
- 6'h00 AND
- 6'h01 OR
- 6'h02 ADD
- 6'h06 SUB
- 6'h07 SLT, signed: result = 1 if A < B, else 0, computed as (A−B) sign XOR overflow
- 6'h0C MULT, unsigned

Any other code gives oResult=0 with oIllegal=1 and oOverflow=0. It is accepted and completes as a single-cycle op.

Acceptance (accept = iValid && oReady):
- oReady = !iRst && state==IDLE && (!oValid || iReady).
- Operands and op are captured only on accept; later changes on iA/iB/iOp are ignored.

State machine: IDLE, MUL.
- **IDLE**, single-cycle op accepted: the result and flags register next edge, oValid=1, state stays IDLE.
- **IDLE**, MULT accepted: load multiplicand = A (zero-extended to 2·DATA_W), multiplier = B, accumulator = 0, counter = 0. Go to MUL; oBusy=1.
- **MUL**, each cycle:
  - If multiplier[0], accumulator += multiplicand.
  - Multiplicand <<= 1, multiplier >>= 1, counter += 1.
  - When counter reaches DATA_W−1, that cycle's update is the final one. On the same edge, oHi/oLo load the accumulator halves, oResult = LO, oValid=1, and state returns to IDLE.

Flags:
- oZero reflects the registered oResult.
- oOverflow is set only for ADD/SUB: the operand signs agree (ADD) or differ (SUB) and the result sign differs from A.
- oOverflow is 0 for MULT.

Output hold: while oValid && !iReady, oResult/flags/oHi/oLo hold steady and no new request is accepted. oValid drops on the edge where iReady=1, unless a new accept occurs on that same edge (back-to-back).

HI/LO are updated only by MULT. Other ops leave them unchanged.

Reset: synchronous. Any cycle with iRst=1 returns state to IDLE, clears the counter, and zeroes all outputs (oValid, oResult, oZero, oOverflow, oIllegal, oHi, oLo, oBusy). oReady is 0 during reset. A multiply in flight is aborted with no result.

## Timing
- Single-cycle ops: latency 1 (accept at edge N, oValid high after edge N). Throughput is 1 per cycle when iReady is held high.
- MULT: latency DATA_W cycles from accept to oValid (32 for default). oReady=0 for the whole MUL period.
- oReady is combinational from state, oValid, iReady and iRst. There is no combinational path from iA/iB/iOp to any output.
- Simultaneous iReady=1 and a new accept: the old result retires and the new result appears after the same edge.
- Reset asserted in the same cycle as accept: reset wins and nothing is captured.

## Test plan
- ADD 32'h7FFFFFFF + 32'h00000001 -> oResult=32'h80000000, oOverflow=1, oZero=0, oValid one cycle after accept.
- SUB 5 − 5 with op 6'h06 -> oResult=0, oZero=1, oOverflow=0. SLT A=32'hFFFFFFFF, B=1 -> oResult=1.
- MULT A=32'hFFFFFFFF, B=32'h00000002 -> after 32 cycles oHi=1, oLo=32'hFFFFFFFE, oResult=oLo. oReady=0 and oBusy=1 throughout.
- Back-pressure: AND 32'hF0F0F0F0 & 32'hFF00FF00 with iReady=0 for 5 cycles -> result 32'hF000F000 held stable, oReady=0. Then iReady=1 with a queued OR request gives the back-to-back result on the next edge.
- Reset at MUL cycle 10 -> next cycle all outputs 0, state IDLE, oReady=1 after iRst drops. A following ADD 2+3 returns 5.
- Illegal op 6'h3F -> oIllegal=1, oResult=0, oHi/oLo unchanged from a prior MULT.
